// File: rtl/estop_request_gen.sv
// Initiator side of the emergency-stop handshake: debounce the panic button, request/confirm the stop, hold until clear-key release.
// Optional feature macro: ESTOP_EVENT_CNT_EN adds the event_count[7:0] output (stop requests issued, saturating).
module estop_request_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned ACK_TIMEOUT     = 8,
  parameter int unsigned CLEAR_HOLD      = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       stop_btn,
  input  logic       clear_key,
  input  logic       emergency_stopped,
  output logic       emergency_stop,
  output logic       alarm,
  output logic       fault,
  output logic [2:0] state
`ifdef ESTOP_EVENT_CNT_EN
  ,
  output logic [7:0] event_count
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQUEST = 3'd1,
    ST_HALTED  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_FAULT   = 3'd4
  } state_e;

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned AT_W = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned CH_W = $clog2(CLEAR_HOLD + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AT_W-1:0] AT_LAST = AT_W'(ACK_TIMEOUT - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CLEAR_HOLD - 1);

  logic            stop_s1_q, stop_s2_q;
  logic            clear_s1_q, clear_s2_q;
  logic            btn_db_q, btn_db_d;
  logic            btn_db_prev_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  state_e          state_q, state_d;
  logic [AT_W-1:0] ack_timer_q, ack_timer_d;
  logic [CH_W-1:0] hold_cnt_q, hold_cnt_d;
  logic            emergency_stop_q, emergency_stop_d;
  logic            alarm_q, alarm_d;
  logic            fault_q, fault_d;
  logic            press;

  // A press is the first cycle the debounced level reads high.
  assign press = btn_db_q & ~btn_db_prev_q;

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (stop_s2_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = ~btn_db_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ack_timer_d = '0;
    hold_cnt_d  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (press) state_d = ST_REQUEST;
      end
      ST_REQUEST: begin
        // An ack arriving on the expiry cycle still counts.
        if (emergency_stopped)         state_d = ST_HALTED;
        else if (ack_timer_q == AT_LAST) state_d = ST_FAULT;
        else                           ack_timer_d = ack_timer_q + AT_W'(1);
      end
      ST_HALTED: begin
        if (!emergency_stopped) begin
          state_d = ST_FAULT;
        end else if (clear_s2_q && !btn_db_q) begin
          if (hold_cnt_q == CH_LAST) state_d = ST_RELEASE;
          else                       hold_cnt_d = hold_cnt_q + CH_W'(1);
        end
      end
      ST_RELEASE: begin
        if (press)                       state_d = ST_REQUEST;
        else if (!emergency_stopped)     state_d = ST_IDLE;
        else if (ack_timer_q == AT_LAST) state_d = ST_FAULT;
        else                             ack_timer_d = ack_timer_q + AT_W'(1);
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    emergency_stop_d = (state_d == ST_REQUEST) || (state_d == ST_HALTED) || (state_d == ST_FAULT);
    alarm_d          = emergency_stop_d;
    fault_d          = (state_d == ST_FAULT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stop_s1_q        <= 1'b0;
      stop_s2_q        <= 1'b0;
      clear_s1_q       <= 1'b0;
      clear_s2_q       <= 1'b0;
      btn_db_q         <= 1'b0;
      btn_db_prev_q    <= 1'b0;
      db_cnt_q         <= '0;
      state_q          <= ST_IDLE;
      ack_timer_q      <= '0;
      hold_cnt_q       <= '0;
      emergency_stop_q <= 1'b0;
      alarm_q          <= 1'b0;
      fault_q          <= 1'b0;
    end else begin
      stop_s1_q        <= stop_btn;
      stop_s2_q        <= stop_s1_q;
      clear_s1_q       <= clear_key;
      clear_s2_q       <= clear_s1_q;
      btn_db_q         <= btn_db_d;
      btn_db_prev_q    <= btn_db_q;
      db_cnt_q         <= db_cnt_d;
      state_q          <= state_d;
      ack_timer_q      <= ack_timer_d;
      hold_cnt_q       <= hold_cnt_d;
      emergency_stop_q <= emergency_stop_d;
      alarm_q          <= alarm_d;
      fault_q          <= fault_d;
    end
  end

  assign emergency_stop = emergency_stop_q;
  assign alarm          = alarm_q;
  assign fault          = fault_q;
  assign state          = state_q;

`ifdef ESTOP_EVENT_CNT_EN
  logic [7:0] event_cnt_q, event_cnt_d;

  always_comb begin
    event_cnt_d = event_cnt_q;
    if ((state_d == ST_REQUEST) && (state_q != ST_REQUEST) && (event_cnt_q != 8'hFF)) begin
      event_cnt_d = event_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) event_cnt_q <= 8'd0;
    else          event_cnt_q <= event_cnt_d;
  end

  assign event_count = event_cnt_q;
`endif

endmodule

// File: tb/tb_estop_request_gen.sv
// Self-checking bench for estop_request_gen: directed test-plan steps followed by randomized traffic,
// all compared every cycle against an event/timestamp reference model.
module tb_estop_request_gen;

  localparam int DB = 4;
  localparam int AT = 8;
  localparam int CH = 32;

  localparam int S_IDLE  = 0;
  localparam int S_REQ   = 1;
  localparam int S_HALT  = 2;
  localparam int S_REL   = 3;
  localparam int S_FAULT = 4;

  typedef enum {ACK_FOLLOW, ACK_LOW, ACK_HIGH, ACK_RAND} ack_mode_e;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       stop_btn = 1'b0;
  logic       clear_key = 1'b0;
  logic       emergency_stopped = 1'b0;
  logic       emergency_stop;
  logic       alarm;
  logic       fault;
  logic [2:0] state;
`ifdef ESTOP_EVENT_CNT_EN
  logic [7:0] event_count;
`endif

  estop_request_gen #(
    .DEBOUNCE_CYCLES(DB),
    .ACK_TIMEOUT    (AT),
    .CLEAR_HOLD     (CH)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .stop_btn         (stop_btn),
    .clear_key        (clear_key),
    .emergency_stopped(emergency_stopped),
    .emergency_stop   (emergency_stop),
    .alarm            (alarm),
    .fault            (fault),
    .state            (state)
`ifdef ESTOP_EVENT_CNT_EN
    ,
    .event_count      (event_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: raw-sample histories, run lengths and entry timestamps.
  bit        m_hist[$];
  bit        m_clr[$];
  bit        m_db = 1'b0;
  bit        m_rose = 1'b0;
  int        m_run = 0;
  int        m_state = S_IDLE;
  int        m_k = 0;
  int        m_entered = 0;
  int        m_hold_since = -1;
  int        m_events = 0;
  ack_mode_e ack_mode = ACK_FOLLOW;

  function automatic bit exp_stop();
    return (m_state == S_REQ) || (m_state == S_HALT) || (m_state == S_FAULT);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] want);
    n_vec++;
    assert (obs === want)
    else begin
      n_err++;
      $error("FAIL %s @edge%0d observed=%0h expected=%0h", tag, m_k, obs, want);
    end
  endtask

  task automatic model_step();
    bit sync_b;
    bit sync_c;
    bit press;
    int nxt;
    if (!reset_n) begin
      m_hist.delete();
      m_clr.delete();
      m_db         = 1'b0;
      m_rose       = 1'b0;
      m_run        = 0;
      m_state      = S_IDLE;
      m_entered    = m_k;
      m_hold_since = -1;
      m_events     = 0;
    end else begin
      // Synchronized value at this edge is the raw sample from two edges earlier.
      sync_b = (m_hist.size() >= 2) ? m_hist[m_hist.size() - 2] : 1'b0;
      sync_c = (m_clr.size() >= 2) ? m_clr[m_clr.size() - 2] : 1'b0;
      press  = m_rose;
      nxt    = m_state;
      case (m_state)
        S_IDLE: if (press) nxt = S_REQ;
        S_REQ: begin
          if (emergency_stopped === 1'b1) nxt = S_HALT;
          else if (m_k - m_entered >= AT) nxt = S_FAULT;
        end
        S_HALT: begin
          if (emergency_stopped !== 1'b1) begin
            nxt = S_FAULT;
          end else if (sync_c && !m_db) begin
            if (m_hold_since < 0) m_hold_since = m_k;
            if (m_k - m_hold_since + 1 >= CH) nxt = S_REL;
          end else begin
            m_hold_since = -1;
          end
        end
        S_REL: begin
          if (press) nxt = S_REQ;
          else if (emergency_stopped !== 1'b1) nxt = S_IDLE;
          else if (m_k - m_entered >= AT) nxt = S_FAULT;
        end
        default: ;
      endcase
      if (nxt == S_REQ && m_state != S_REQ && m_events < 255) m_events++;
      if (nxt != m_state) begin
        m_entered    = m_k;
        m_hold_since = -1;
      end
      m_state = nxt;

      m_rose = 1'b0;
      if (sync_b != m_db) begin
        m_run++;
        if (m_run == DB) begin
          m_db   = ~m_db;
          m_run  = 0;
          m_rose = m_db;
        end
      end else begin
        m_run = 0;
      end

      m_hist.push_back(stop_btn);
      m_clr.push_back(clear_key);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
      if (m_clr.size() > 4) void'(m_clr.pop_front());
    end
    m_k++;
  endtask

  task automatic tick();
    bit pre_stop;
    pre_stop = exp_stop();
    model_step();
    @(posedge clk);
    #1;
    check("cyc state", 8'(state), 8'(m_state));
    check("cyc emergency_stop", 8'(emergency_stop), 8'(exp_stop()));
    check("cyc alarm", 8'(alarm), 8'(exp_stop()));
    check("cyc fault", 8'(fault), 8'(m_state == S_FAULT));
`ifdef ESTOP_EVENT_CNT_EN
    check("cyc event_count", event_count, 8'(m_events));
`endif
    // Controller stand-in: registered echo of the request, or forced levels.
    case (ack_mode)
      ACK_FOLLOW: emergency_stopped = pre_stop;
      ACK_LOW:    emergency_stopped = 1'b0;
      ACK_HIGH:   emergency_stopped = 1'b1;
      default:    emergency_stopped = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic stop_and_clear();
    stop_btn = 1'b1;
    ticks(12);
    stop_btn = 1'b0;
    ticks(8);
    clear_key = 1'b1;
    ticks(36);
    clear_key = 1'b0;
    ticks(4);
    check("cycle back idle", 8'(state), 8'(S_IDLE));
  endtask

  initial begin
    reset_n = 1'b0;
    ticks(2);
    check("rst state", 8'(state), 8'd0);
    check("rst emergency_stop", 8'(emergency_stop), 8'd0);
    check("rst alarm", 8'(alarm), 8'd0);
    check("rst fault", 8'(fault), 8'd0);
    reset_n  = 1'b1;
    ack_mode = ACK_FOLLOW;

    // Basic stop: press held from cycle 0, controller echoes one cycle later.
    stop_btn = 1'b1;
    ticks(6);
    check("basic stop low@6", 8'(emergency_stop), 8'd0);
    tick();
    check("basic stop high@7", 8'(emergency_stop), 8'd1);
    ticks(2);
    check("basic halted@9", 8'(state), 8'(S_HALT));
    check("basic alarm", 8'(alarm), 8'd1);

    // Clear release: an interrupted hold must not count.
    stop_btn = 1'b0;
    ticks(10);
    check("halted before clear", 8'(state), 8'(S_HALT));
    clear_key = 1'b1;
    ticks(20);
    clear_key = 1'b0;
    tick();
    clear_key = 1'b1;
    ticks(33);
    check("clear not early", 8'(state), 8'(S_HALT));
    tick();
    check("clear release", 8'(state), 8'(S_REL));
    check("release stop low", 8'(emergency_stop), 8'd0);
    ticks(2);
    check("release to idle", 8'(state), 8'(S_IDLE));
    clear_key = 1'b0;
    ticks(2);

    stop_and_clear();
    stop_and_clear();
`ifdef ESTOP_EVENT_CNT_EN
    check("event_count after 3", event_count, 8'd3);
`endif
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
`ifdef ESTOP_EVENT_CNT_EN
    check("event_count after reset", event_count, 8'd0);
`endif

    // Bounce rejection: toggling every 2 cycles never survives the debounce.
    for (int i = 0; i < 20; i++) begin
      stop_btn = ~stop_btn;
      ticks(2);
      check("bounce btn_db", 8'(dut.btn_db_q), 8'd0);
    end
    stop_btn = 1'b0;
    ticks(4);
    check("bounce stop low", 8'(emergency_stop), 8'd0);
    check("bounce idle", 8'(state), 8'(S_IDLE));

    // Ack timeout: controller never answers.
    ack_mode = ACK_LOW;
    stop_btn = 1'b1;
    ticks(14);
    check("timeout still request", 8'(state), 8'(S_REQ));
    tick();
    check("timeout fault state", 8'(state), 8'(S_FAULT));
    check("timeout fault flag", 8'(fault), 8'd1);
    ticks(5);
    check("fault holds stop", 8'(emergency_stop), 8'd1);
    reset_n = 1'b0;
    tick();
    check("reset drops stop", 8'(emergency_stop), 8'd0);
    check("reset clears fault", 8'(fault), 8'd0);
    reset_n  = 1'b1;
    stop_btn = 1'b0;
    ack_mode = ACK_FOLLOW;
    ticks(4);

    // Re-press while RELEASE waits for the ack to fall.
    stop_btn = 1'b1;
    ticks(12);
    stop_btn = 1'b0;
    ticks(8);
    check("repress halted", 8'(state), 8'(S_HALT));
    ack_mode  = ACK_HIGH;
    clear_key = 1'b1;
    ticks(29);
    stop_btn = 1'b1;
    ticks(5);
    check("repress in release", 8'(state), 8'(S_REL));
    check("repress release stop low", 8'(emergency_stop), 8'd0);
    tick();
    check("repress still release", 8'(state), 8'(S_REL));
    tick();
    check("repress request", 8'(state), 8'(S_REQ));
    check("repress stop high", 8'(emergency_stop), 8'd1);
    check("repress no fault", 8'(fault), 8'd0);
    clear_key = 1'b0;
    ack_mode  = ACK_FOLLOW;
    stop_btn  = 1'b0;
    ticks(10);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;

    // Randomized segments against the model.
    for (int seg = 0; seg < 120; seg++) begin
      stop_btn  = 1'($urandom_range(0, 1));
      clear_key = 1'($urandom_range(0, 1));
      ack_mode  = ($urandom_range(0, 9) < 7) ? ACK_FOLLOW : ACK_RAND;
      reset_n   = ($urandom_range(0, 49) != 0);
      ticks(int'($urandom_range(1, 50)));
      reset_n = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
